// File: rtl/regalu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regalu_seq_ctrl
//  Brief    : Multi-cycle DECODE/EXEC/MEM/WB control sequencer for the
//             RV32I register-file + ALU lab datapath.
//  Options  : SEQ_PERF_CNT_EN adds cycle_cnt / retire_cnt outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module regalu_seq_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic [6:0]  func5,
  output logic [11:0] imm,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        PCSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUOp0,
  output logic        ALUOp1,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [7:0] WAIT_LIMIT = MEM_WAIT_MAX[7:0];

  logic [2:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       is_r, is_i, is_ld, is_st, is_br, legal;
  logic       in_ops;

  assign opcode = instr_q[6:0];
  assign f3     = instr_q[14:12];

  // Legality folds func3 restrictions in, so every is_* flag means "executable".
  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LD) && (f3 == 3'b010);
  assign is_st = (opcode == OP_ST) && (f3 == 3'b010);
  assign is_br = (opcode == OP_BR) && (f3[2:1] == 2'b00);
  assign legal = is_r | is_i | is_ld | is_st | is_br;

  assign busy        = (state_q != ST_IDLE);
  assign instr_ready = (state_q == ST_IDLE) && !reset;
  assign in_ops      = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  assign rs1   = busy ? instr_q[19:15] : 5'd0;
  assign rs2   = busy ? instr_q[24:20] : 5'd0;
  assign rd    = busy ? instr_q[11:7]  : 5'd0;
  assign func3 = busy ? f3             : 3'd0;
  assign func5 = busy ? instr_q[31:25] : 7'd0;

  always_comb begin
    imm = 12'd0;
    if (busy) begin
      if (is_i || is_ld) imm = instr_q[31:20];
      else if (is_st)    imm = {instr_q[31:25], instr_q[11:7]};
      else if (is_br)    imm = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
    end
  end

  assign ALUSrc = busy && (is_i || is_ld || is_st);
  assign ALUOp1 = in_ops && (is_r || is_i);
  assign ALUOp0 = in_ops && is_br;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    RegWrite   = 1'b0;
    PCSrc      = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wait_cnt_d = 8'd0;
        if (is_r || is_i) begin
          state_d = ST_WB;
        end else if (is_ld || is_st) begin
          state_d = ST_MEM;
        end else begin
          PCSrc   = f3[0] ? ~alu_zero : alu_zero;
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        // The timeout cycle itself carries no strobe, so the strobe lasts exactly MEM_WAIT_MAX cycles.
        if (wait_cnt_q == WAIT_LIMIT) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          MemRead  = is_ld;
          MemWrite = is_st;
          if (mem_ack) begin
            if (is_ld) begin
              state_d = ST_WB;
            end else begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ST_WB: begin
        RegWrite = (instr_q[11:7] != 5'd0);
        MemToReg = is_ld;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= 32'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= 32'd0;
      retire_cnt <= 32'd0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      retire_cnt <= retire_cnt + {31'd0, done};
    end
  end
`endif

endmodule
`default_nettype wire
